// File: rtl/hex_disp_ctrl_pkg.sv
// Shared constants for the hex display controller: active-low 7-segment font
// (bit order g..a), the dark pattern and a counter-width helper.
package hex_disp_ctrl_pkg;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_disp_ctrl_font_rom.sv
// Combinational hex-to-segment decoder shared by all digits of the display.
module hex_font_rom
  import hex_disp_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // All 16 codes are defined, so the output is always a valid pattern.
  always_comb begin
    seg_o = FONT[nib_i];
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Scanned 7-segment controller: shadow/active value with frame-boundary commit,
// leading-zero suppression, live blank/blink masks and a registered output bank.
module hex_disp_ctrl
  import hex_disp_ctrl_pkg::*;
#(
  parameter int NDIG      = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                load_i,
  input  logic [4*NDIG-1:0]   value_i,
  input  logic                lz_en_i,
  input  logic [NDIG-1:0]     blank_mask_i,
  input  logic [NDIG-1:0]     blink_mask_i,
  output logic                pending_o,
  output logic                frame_o,
  output logic [7*NDIG-1:0]   hex_o
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(NDIG);
  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [4*NDIG-1:0]   shadow_q, active_q;
  logic                shadow_lz_q, active_lz_q, pending_q;
  logic [7*NDIG-1:0]   hex_q, hex_d;
  logic                frame_q;

  logic                slot_edge_s, commit_s, blink_wrap_s, zero_run_s, dark_s;
  logic [NDIG-1:0]     sup_s;
  logic [3:0]          nib_s;
  logic [6:0]          seg_s;

  assign slot_edge_s  = (scan_cnt_q == SCAN_LAST);
  assign commit_s     = slot_edge_s && (idx_q == IDX_LAST);
  assign blink_wrap_s = (blink_cnt_q == BLINK_LAST);

  // Scan and blink counter next state.
  always_comb begin
    scan_cnt_d    = slot_edge_s ? '0 : scan_cnt_q + SW'(1);
    idx_d         = slot_edge_s ? ((idx_q == IDX_LAST) ? '0 : idx_q + IW'(1)) : idx_q;
    blink_cnt_d   = blink_wrap_s ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap_s;
  end

  // Leading-zero suppression: walk down from the top digit while nibbles stay zero.
  always_comb begin
    zero_run_s = 1'b1;
    sup_s      = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s & (active_q[4*k +: 4] == 4'h0);
      sup_s[k]   = active_lz_q & zero_run_s & (k != 0);
    end
  end

  // Select the nibble and dark condition of the digit owning the current slot.
  always_comb begin
    nib_s  = 4'h0;
    dark_s = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      nib_s  = (idx_q == IW'(k)) ? active_q[4*k +: 4] : nib_s;
      dark_s = (idx_q == IW'(k)) ? (blank_mask_i[k] | (blink_mask_i[k] & blink_phase_q) | sup_s[k])
                                 : dark_s;
    end
  end

  hex_font_rom u_font (
    .nib_i (nib_s),
    .seg_o (seg_s)
  );

  // Only the digit owning this slot edge is rewritten; the rest hold.
  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      hex_d[7*k +: 7] = (slot_edge_s && (idx_q == IW'(k))) ? (dark_s ? SEG_DARK : seg_s)
                                                          : hex_q[7*k +: 7];
    end
  end

  // Counters, output bank and frame pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hex_q         <= '1;
      frame_q       <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hex_q         <= hex_d;
      frame_q       <= commit_s;
    end
  end

  // Shadow capture and frame-boundary commit; a load on the commit edge keeps pending set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shadow_q    <= '0;
      shadow_lz_q <= 1'b0;
      active_q    <= '0;
      active_lz_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_q    <= value_i;
        shadow_lz_q <= lz_en_i;
        pending_q   <= 1'b1;
      end else if (commit_s) begin
        pending_q   <= 1'b0;
      end else begin
        pending_q   <= pending_q;
      end
      if (commit_s && pending_q) begin
        active_q    <= shadow_q;
        active_lz_q <= shadow_lz_q;
      end else begin
        active_q    <= active_q;
        active_lz_q <= active_lz_q;
      end
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = frame_q;
  assign hex_o     = hex_q;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Self-checking bench for hex_disp_ctrl: table of load vectors with a scoreboard
// queue, plus hand-written reset, load-collision, mask and mid-frame-reset sequences.
module tb_hex_disp_ctrl;

  localparam int NDIG      = 6;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = NDIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        load_i = 1'b0;
  logic [23:0] value_i = 24'h0;
  logic        lz_en_i = 1'b0;
  logic [5:0]  blank_mask_i = 6'h0;
  logic [5:0]  blink_mask_i = 6'h0;
  logic        pending_o, frame_o;
  logic [41:0] hex_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [41:0] exp_q [$];

  typedef struct {
    logic [23:0] value;
    logic        lz;
    logic [5:0]  blank;
    logic [41:0] exp;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  hex_disp_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .load_i       (load_i),
    .value_i      (value_i),
    .lz_en_i      (lz_en_i),
    .blank_mask_i (blank_mask_i),
    .blink_mask_i (blink_mask_i),
    .pending_o    (pending_o),
    .frame_o      (frame_o),
    .hex_o        (hex_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] model(input logic [23:0] v, input logic lz, input logic [5:0] dark);
    logic [41:0] r;
    logic zr;
    zr = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      zr = zr && (v[4*k +: 4] == 4'h0);
      r[7*k +: 7] = (dark[k] || (lz && zr && k > 0)) ? 7'h7F : font(v[4*k +: 4]);
    end
    return r;
  endfunction

  task automatic wait_frame(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_o && c < 3 * FRAME);
    if (!frame_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no frame_o pulse within %0d cycles", name, 3 * FRAME);
    end
  endtask

  task automatic wait_commit(input string name);
    int c;
    c = 0;
    while (pending_o && c < 3 * FRAME) begin
      @(negedge clk);
      c++;
    end
    check(name, pending_o, 1'b0);
  endtask

  task automatic do_load(input logic [23:0] v, input logic lz);
    @(negedge clk);
    value_i = v;
    lz_en_i = lz;
    load_i  = 1'b1;
    @(negedge clk);
    load_i  = 1'b0;
    check("pending_set", pending_o, 1'b1);
  endtask

  task automatic release_check(input string name);
    int first_frame;
    first_frame = -1;
    @(negedge clk);
    clrn = 1'b1;
    for (int c = 1; c <= FRAME + 2; c++) begin
      @(negedge clk);
      if (c == 3) check({name, "_pre_write"}, hex_o, {42{1'b1}});
      if (c == 4) check({name, "_first_write"}, hex_o, {{35{1'b1}}, 7'h40});
      if (frame_o && first_frame < 0) first_frame = c;
    end
    check({name, "_first_frame"}, first_frame, FRAME);
    check({name, "_pending"}, pending_o, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] val_b, val_c;
    logic [6:0]  d5;
    logic [41:0] lower_exp;
    int trans, bad, dark_n, lit_n;

    tbl[0] = '{24'h12AB3F, 1'b0, 6'h00, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}};
    tbl[1] = '{24'h000050, 1'b1, 6'h00, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}};
    tbl[2] = '{24'h000000, 1'b1, 6'h00, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[3] = '{24'h000000, 1'b0, 6'h00, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[4] = '{24'h0F0000, 1'b1, 6'h00, {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[5] = '{24'hFEDCBA, 1'b1, 6'h00, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
    tbl[6] = '{24'h000100, 1'b1, 6'h00, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
    tbl[7] = '{24'h987654, 1'b0, 6'h00, {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}};
    tbl[8] = '{24'h00000A, 1'b1, 6'h00, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08}};
    tbl[9] = '{24'h123456, 1'b0, 6'h01, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F}};

    // Reset state and first-frame timing.
    repeat (3) @(negedge clk);
    check("rst_hex", hex_o, {42{1'b1}});
    check("rst_pending", pending_o, 1'b0);
    check("rst_frame", frame_o, 1'b0);
    release_check("boot");

    // Table-driven load/commit vectors.
    for (int i = 0; i < 10; i++) begin
      blank_mask_i = tbl[i].blank;
      do_load(tbl[i].value, tbl[i].lz);
      exp_q.push_back(tbl[i].exp);
      wait_commit("commit");
      wait_frame("vec_frame");
      check($sformatf("vec%0d", i), hex_o, exp_q.pop_front());
    end
    blank_mask_i = 6'h00;

    // Load collision: A and B mid-frame, C on the commit edge.
    val_b = 24'h00C0DE;
    val_c = 24'h7E5A09;
    wait_frame("coll_sync");
    repeat (4) @(negedge clk);
    value_i = 24'h111111; lz_en_i = 1'b0; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (4) @(negedge clk);
    value_i = val_b; lz_en_i = 1'b1; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (13) @(negedge clk);
    value_i = val_c; lz_en_i = 1'b0; load_i = 1'b1;
    exp_q.push_back(model(val_b, 1'b1, 6'h00));
    exp_q.push_back(model(val_c, 1'b0, 6'h00));
    @(negedge clk);
    load_i = 1'b0;
    check("coll_align", frame_o, 1'b1);
    check("coll_pending", pending_o, 1'b1);
    wait_frame("coll_f1");
    check("coll_show_b", hex_o, exp_q.pop_front());
    check("coll_c_committed", pending_o, 1'b0);
    wait_frame("coll_f2");
    check("coll_show_c", hex_o, exp_q.pop_front());

    // Blank mask on digit 0.
    blank_mask_i = 6'b000001;
    wait_frame("blank_f1");
    wait_frame("blank_f2");
    check("blank_d0", hex_o, model(val_c, 1'b0, 6'b000001));
    blank_mask_i = 6'b000000;
    wait_frame("unblank_f1");
    wait_frame("unblank_f2");
    check("unblank", hex_o, model(val_c, 1'b0, 6'h00));

    // Blink mask on digit 5: only lit/dark values, toggling at the blink rate.
    blink_mask_i = 6'b100000;
    lower_exp = model(val_c, 1'b0, 6'h00);
    trans = 0; bad = 0; dark_n = 0; lit_n = 0;
    @(negedge clk);
    d5 = hex_o[41:35];
    for (int c = 0; c < 6 * BLINK_DIV; c++) begin
      @(negedge clk);
      if (hex_o[41:35] !== d5) trans++;
      d5 = hex_o[41:35];
      if (d5 === 7'h7F) dark_n++;
      else if (d5 === font(val_c[23:20])) lit_n++;
      else bad++;
      if (hex_o[34:0] !== lower_exp[34:0]) bad++;
    end
    check("blink_bad_values", bad, 0);
    check("blink_saw_dark", dark_n > 0, 1'b1);
    check("blink_saw_lit", lit_n > 0, 1'b1);
    check("blink_rate", (trans >= 4 && trans <= 7), 1'b1);
    blink_mask_i = 6'h00;

    // Mid-frame asynchronous reset while idx=3 and a load is pending.
    wait_frame("mrst_sync");
    do_load(24'h654321, 1'b0);
    repeat (11) @(negedge clk);
    check("mrst_pre_pending", pending_o, 1'b1);
    #1 clrn = 1'b0;
    #1;
    check("mrst_hex", hex_o, {42{1'b1}});
    check("mrst_pending", pending_o, 1'b0);
    check("mrst_frame", frame_o, 1'b0);
    repeat (2) @(negedge clk);
    release_check("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_disp_ctrl.md
Name: hex_disp_ctrl

Overview:
- Display controller for a bank of NDIG active-low 7-segment digits, 0–F font.
- Holds a shadow and an active hex value.
- Commits new values only at frame boundaries, so the display never tears.
- Time-shares one hex-to-segment decoder across all digits with a scan counter.
- Applies leading-zero suppression, per-digit blanking and per-digit blinking.
- Sits between keyboard/character-input logic and the board HEX displays.

Parameters:
- NDIG, 6, number of digits; digit 0 is least significant.
- SCAN_DIV, 50000, clock cycles per digit refresh slot; must be >= 2.
- BLINK_DIV, 12500000, clock cycles per blink phase toggle; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- load_i  in  1  single-cycle strobe: capture value_i and lz_en_i into the shadow.
- value_i  in  4*NDIG  hex value; nibble k belongs to digit k.
- lz_en_i  in  1  leading-zero suppression enable, captured with value_i.
- blank_mask_i  in  NDIG  live mask; a set bit forces that digit dark.
- blink_mask_i  in  NDIG  live mask; a set bit blanks that digit while blink_phase=1.
- pending_o  out  1  shadow holds an uncommitted value.
- frame_o  out  1  one-cycle pulse when the last digit slot of a frame is written.
- hex_o  out  7*NDIG  segments for digit k at [7k+6:7k]; active-low, bit order g..a.

Behaviour:
- Reset (clrn=0, asynchronous):
  - hex_o all ones (dark).
  - shadow, active value, scan_cnt, idx, blink_cnt and blink_phase cleared; lz flags cleared.
  - pending_o=0, frame_o=0.
- Reset mid-frame aborts the scan; after release, scanning restarts at idx=0, scan_cnt=0.
- Scan counter:
  - scan_cnt runs 0..SCAN_DIV-1 and wraps.
  - At scan_cnt=SCAN_DIV-1 (slot edge), digit idx is written: hex_o[idx] <= dark ? 7'h7F : font(nibble).
  - Then idx advances; it wraps from NDIG-1 to 0.
- dark is true for digit idx when any of these holds:
  - blank_mask_i[idx]=1;
  - blink_mask_i[idx]=1 and blink_phase=1;
  - the digit is leading-zero suppressed.
- Leading-zero suppression:
  - Applies when active lz_en=1.
  - Digit k>0 is suppressed when its nibble and all higher nibbles are 0.
  - Digit 0 is never suppressed.
  - Computed from the active value only.
- Font is 0 to 7'h40, 1 to 7'h79, through F to 7'h0E. It is defined for all 16 codes; no high-Z or X ever reaches hex_o.
- Unwritten digits hold their last value between slot edges.
- frame_o pulses in the clock cycle after the slot edge that writes idx=NDIG-1.
- Commit:
  - Occurs on that same slot edge (idx=NDIG-1).
  - If pending=1: active <= shadow, active lz_en <= shadow lz_en, pending cleared.
  - The next frame therefore displays the new value from digit 0.
- Load:
  - load_i=1 writes the shadow and sets pending=1.
  - Last load wins if several arrive before a commit.
  - If load_i=1 on the commit edge, the commit takes the pre-edge shadow. The new value enters the shadow and pending stays 1.
- Latency: from load_i to every digit showing the new value is at most 2*NDIG*SCAN_DIV cycles.
- Blink: blink_cnt runs 0..BLINK_DIV-1; blink_phase toggles at wrap. blink_phase is free-running and is not aligned to frames.
- Masks are sampled at each digit's slot edge. A mask change takes effect on that digit's next slot edge.

Decomposition:
- Shared package:
  - font constants: 16 entries, 7 bits each;
  - SEG_DARK = 7'h7F;
  - helper function returning the counter width (clog2).
- One natural sub-module: hex_font_rom.
  - Combinational 4-bit to 7-bit decode, instanced once.
  - Input is the muxed nibble of active[idx].
- Scan counter, blink counter, shadow/commit logic and the output register bank stay in the top level.

Test Plan (SCAN_DIV=4, BLINK_DIV=64, NDIG=6):
- Reset:
  - Hold clrn=0, then release.
  - hex_o == all ones and pending_o=0.
  - First digit write occurs at cycle 4; first frame_o pulse follows 24 cycles after release.
- Load and commit:
  - Load 24'h12AB3F, lz_en=0.
  - pending_o=1 until the frame end, then 0.
  - After the next full frame, digits 5..0 = 7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E.
- Leading-zero suppression:
  - Load 24'h000050, lz_en=1.
  - Digits 5..2 read 7'h7F; digit 1 = 7'h12; digit 0 = 7'h40.
  - Load 24'h000000: only digit 0 lit (7'h40).
- Load collision:
  - Pulse load with A mid-frame, B mid-frame, then C exactly on the commit edge.
  - The next frame shows B; pending_o stays 1.
  - The frame after shows C.
- Masks:
  - blank_mask=6'b000001: digit 0 reads 7'h7F within one frame.
  - blink_mask=6'b100000: digit 5 alternates between lit and 7'h7F every 64 cycles (±1 frame).
- Mid-frame reset:
  - Assert clrn low at idx=3.
  - hex_o immediately all ones (asynchronous); pending_o=0.
  - Scanning resumes at idx=0 after release.
